// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// latency counter sizing and byte-lane helpers.
package dm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    localparam int LAT_MAX = 15;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam int LANE_W  = 2;
    localparam int BYTE_W  = 8;

    // Bit offset of byte lane n inside a little-endian 32-bit word.
    function automatic logic [4:0] lane_shift(input logic [LANE_W-1:0] lane);
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/dm_if.sv
// Load/store bus between the CPU (master) and the data-memory responder (slave).
// A request transfers on an edge where req_valid && req_ready; a response transfers on an
// edge where rsp_valid && rsp_ready; the sender holds valid and its payload until that edge.
interface dm_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dm_byte_lane.sv
// Combinational byte-lane unit: merges a store into the old word and extracts
// (sign-extended) load data for byte or word accesses.
module dm_byte_lane
    import dm_pkg::*;
(
    input  logic [31:0]       old_word_i,
    input  logic [31:0]       wdata_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic              byte_i,
    output logic [31:0]       store_word_o,
    output logic [31:0]       load_data_o
);

    logic [4:0]        sh;
    logic [31:0]       lane_mask;
    logic [BYTE_W-1:0] rd_byte;

    always_comb begin
        sh        = lane_shift(lane_i);
        lane_mask = 32'h0000_00FF << sh;
        rd_byte   = old_word_i[sh +: BYTE_W];
        if (byte_i) begin
            store_word_o = (old_word_i & ~lane_mask) | ({24'h0, wdata_i[7:0]} << sh);
            load_data_o  = {{24{rd_byte[7]}}, rd_byte};
        end else begin
            store_word_o = wdata_i;
            load_data_o  = old_word_i;
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder with programmable latency between request accept and response.
// Optional macro DM_MISALIGN_ERR_EN: misaligned word accesses return rsp_err instead of being aligned.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic      clk,
    input  logic      reset,
    dm_if.slave       bus,
    output dm_state_e dbg_state_o
);

    localparam int  IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit  SKIP_WAIT = (LATENCY == 1);

    dm_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;
    logic              we_q;
    logic              byte_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LANE_W-1:0] lane_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [ADDR_W-1:0] req_addr;
    logic              unused_addr_hi;
    logic              accept;
    logic              commit;
    logic              misalign;
    logic              cur_we;
    logic              cur_byte;
    logic [IDX_W-1:0]  cur_idx;
    logic [LANE_W-1:0] cur_lane;
    logic [31:0]       cur_wdata;
    logic [31:0]       old_word;
    logic [31:0]       store_word;
    logic [31:0]       load_data;

    assign req_addr       = bus.req_addr;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];

    // With LATENCY==1 the commit happens on the accept edge, so it must see the live request.
    always_comb begin
        accept = (state_q == ST_IDLE) && bus.req_valid && req_ready_q;
        if (state_q == ST_IDLE) begin
            cur_we    = bus.req_we;
            cur_byte  = bus.req_byte;
            cur_idx   = req_addr[IDX_W+1:2];
            cur_lane  = req_addr[1:0];
            cur_wdata = bus.req_wdata;
        end else begin
            cur_we    = we_q;
            cur_byte  = byte_q;
            cur_idx   = idx_q;
            cur_lane  = lane_q;
            cur_wdata = wdata_q;
        end
        commit = (accept && SKIP_WAIT) || ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));
`ifdef DM_MISALIGN_ERR_EN
        misalign = !cur_byte && (cur_lane != '0);
`else
        misalign = 1'b0;
`endif
        old_word = mem_q[cur_idx];
    end

    dm_byte_lane u_byte_lane (
        .old_word_i   (old_word),
        .wdata_i      (cur_wdata),
        .lane_i       (cur_lane),
        .byte_i       (cur_byte),
        .store_word_o (store_word),
        .load_data_o  (load_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            idx_q       <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        we_q        <= cur_we;
                        byte_q      <= cur_byte;
                        idx_q       <= cur_idx;
                        lane_q      <= cur_lane;
                        wdata_q     <= cur_wdata;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: cnt_q <= cnt_q - CNT_W'(1);
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Commit edge: the only edge on which memory is read or written.
            if (commit) begin
                state_q     <= ST_RESP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= misalign;
                rsp_rdata_q <= (cur_we || misalign) ? 32'h0 : load_data;
                if (cur_we && !misalign) mem_q[cur_idx] <= store_word;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state_o   = state_q;

endmodule
